video2ram_window: RTL and testbench

- Parametrised successor to the capture-side video-to-line-buffer writer.
- Samples RGB pixels inside a per-mode capture window, given by the counterX/counterY raster position.
- Writes the pixels into a circular line-buffer RAM of BUFFER_LINES lines, using incrementing address counters instead of a multiply.
- Emits exactly one start-trigger per frame for the output pipeline.
- Sits between the video input decoder and the dual-clock line-buffer RAM.

---
 rtl/video2ram_pkg.sv | 32 +++
 rtl/video2ram_addr_gen.sv | 55 +++++
 rtl/video2ram_window.sv | 158 +++++++++++++++
 tb/tb_video2ram_window.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video2ram_pkg.sv
// rtl/video2ram_pkg.sv - shared types, window defaults and helpers for the video-to-RAM writer
package video2ram_pkg;

    typedef enum logic {
        MODE_PROGRESSIVE = 1'b0,
        MODE_DOUBLER     = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WAIT_LINE  = 2'd1,
        CAPTURE    = 2'd2,
        LINE_DONE  = 2'd3
    } state_t;

    localparam int DEF_H_START_P   = 44;
    localparam int DEF_V_END_P     = 480;
    localparam int DEF_H_START_D   = 1;
    localparam int DEF_V_END_D     = 504;
    localparam int DEF_GAP_START_D = 240;
    localparam int DEF_GAP_END_D   = 262;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/video2ram_addr_gen.sv
// rtl/video2ram_addr_gen.sv - ring slot, line base and pixel offset counters for the line buffer
module video2ram_addr_gen
    import video2ram_pkg::*;
#(
    parameter int ADDR_BITS    = 14,
    parameter int LINE_PIXELS  = 640,
    parameter int BUFFER_LINES = 16,
    parameter int SLOT_BITS    = 4,
    parameter int XOFF_BITS    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_clear,
    input  logic                 capture,
    input  logic                 line_done,
    output logic [ADDR_BITS-1:0] addr,
    output logic [SLOT_BITS-1:0] slot,
    output logic                 first_pass,
    output logic                 last_pixel
);

    logic [ADDR_BITS-1:0] base;
    logic [XOFF_BITS-1:0] xoff;

    // base tracks slot*LINE_PIXELS incrementally so no multiplier is needed
    assign addr       = base + ADDR_BITS'(xoff);
    assign last_pixel = (xoff == XOFF_BITS'(LINE_PIXELS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            base       <= '0;
            xoff       <= '0;
            slot       <= '0;
            first_pass <= 1'b0;
        end else if (frame_clear) begin
            base       <= '0;
            xoff       <= '0;
            slot       <= '0;
            first_pass <= 1'b1;
        end else if (line_done) begin
            xoff <= '0;
            if (slot == SLOT_BITS'(BUFFER_LINES - 1)) begin
                slot       <= '0;
                base       <= '0;
                first_pass <= 1'b0;
            end else begin
                slot <= slot + SLOT_BITS'(1);
                base <= base + ADDR_BITS'(LINE_PIXELS);
            end
        end else if (capture) begin
            xoff <= xoff + XOFF_BITS'(1);
        end
    end

endmodule

// File: rtl/video2ram_window.sv
// rtl/video2ram_window.sv - captures a per-mode raster window into a circular line-buffer RAM
module video2ram_window
    import video2ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int ADDR_BITS    = 14,
    parameter int LINE_PIXELS  = 640,
    parameter int BUFFER_LINES = 16,
    parameter int TRIGGER_ADDR = 5120,
    parameter int H_START_P    = DEF_H_START_P,
    parameter int V_END_P      = DEF_V_END_P,
    parameter int H_START_D    = DEF_H_START_D,
    parameter int V_END_D      = DEF_V_END_D,
    parameter int GAP_START_D  = DEF_GAP_START_D,
    parameter int GAP_END_D    = DEF_GAP_END_D,
    parameter int SLOT_BITS    = (clog2(BUFFER_LINES) < 1) ? 1 : clog2(BUFFER_LINES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH/3-1:0] R,
    input  logic [DATA_WIDTH/3-1:0] G,
    input  logic [DATA_WIDTH/3-1:0] B,
    input  logic [11:0]             counterX,
    input  logic [11:0]             counterY,
    input  logic                    line_doubler,
    output logic [DATA_WIDTH-1:0]   wrdata,
    output logic [ADDR_BITS-1:0]    wraddr,
    output logic                    wren,
    output logic                    wrclock,
    output logic                    starttrigger,
    output logic [SLOT_BITS-1:0]    line_slot,
    output logic                    frame_active
);

    localparam int XOFF_BITS = clog2(LINE_PIXELS + 1);
    localparam bit TRIG_REACHABLE = (TRIGGER_ADDR < BUFFER_LINES * LINE_PIXELS);
    localparam logic [ADDR_BITS-1:0] TRIG_ADDR_W = ADDR_BITS'(TRIGGER_ADDR);

    state_t               state_q, state_d;
    mode_t                mode_q;
    logic                 trig_done;
    logic                 frame_start;
    logic                 in_gap;
    logic [11:0]          h_start;
    logic [11:0]          v_end;
    logic                 frame_clear;
    logic                 capture;
    logic                 line_done;
    logic                 end_frame;
    logic [ADDR_BITS-1:0] cur_addr;
    logic                 first_pass;
    logic                 last_pixel;

    assign wrclock     = clock;
    assign frame_start = (counterX == 12'd0) && (counterY == 12'd0);

    // window limits follow the mode latched at frame start, not the live input
    assign h_start = (mode_q == MODE_DOUBLER) ? 12'(H_START_D) : 12'(H_START_P);
    assign v_end   = (mode_q == MODE_DOUBLER) ? 12'(V_END_D)   : 12'(V_END_P);
    assign in_gap  = (mode_q == MODE_DOUBLER) &&
                     (counterY >= 12'(GAP_START_D)) && (counterY <= 12'(GAP_END_D));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_clear = 1'b0;
        capture     = 1'b0;
        line_done   = 1'b0;
        end_frame   = 1'b0;
        if (frame_start) begin
            // a frame start anywhere restarts the frame and drops any partial line
            frame_clear = 1'b1;
            state_d     = WAIT_LINE;
        end else begin
            unique case (state_q)
                WAIT_FRAME: state_d = WAIT_FRAME;
                WAIT_LINE: begin
                    if ((counterX == h_start) && (counterY < v_end) && !in_gap) begin
                        capture = 1'b1;
                        state_d = last_pixel ? LINE_DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    capture = 1'b1;
                    if (last_pixel) begin
                        state_d = LINE_DONE;
                    end
                end
                LINE_DONE: begin
                    line_done = 1'b1;
                    if (counterY >= v_end - 12'd1) begin
                        end_frame = 1'b1;
                        state_d   = WAIT_FRAME;
                    end else begin
                        state_d = WAIT_LINE;
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    video2ram_addr_gen #(
        .ADDR_BITS    (ADDR_BITS),
        .LINE_PIXELS  (LINE_PIXELS),
        .BUFFER_LINES (BUFFER_LINES),
        .SLOT_BITS    (SLOT_BITS),
        .XOFF_BITS    (XOFF_BITS)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .frame_clear (frame_clear),
        .capture     (capture),
        .line_done   (line_done),
        .addr        (cur_addr),
        .slot        (line_slot),
        .first_pass  (first_pass),
        .last_pixel  (last_pixel)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wren         <= 1'b0;
            wrdata       <= '0;
            wraddr       <= '0;
            starttrigger <= 1'b0;
            trig_done    <= 1'b0;
            frame_active <= 1'b0;
            mode_q       <= MODE_PROGRESSIVE;
        end else begin
            wren         <= capture;
            starttrigger <= 1'b0;
            if (capture) begin
                wrdata <= DATA_WIDTH'({R, G, B});
                wraddr <= cur_addr;
                if (TRIG_REACHABLE && (cur_addr == TRIG_ADDR_W) && first_pass && !trig_done) begin
                    starttrigger <= 1'b1;
                    trig_done    <= 1'b1;
                end
            end
            if (frame_clear) begin
                mode_q       <= line_doubler ? MODE_DOUBLER : MODE_PROGRESSIVE;
                trig_done    <= 1'b0;
                frame_active <= 1'b1;
            end else if (end_frame) begin
                frame_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video2ram_window.sv
// tb/tb_video2ram_window.sv - directed bench for video2ram_window on a scaled-down raster
module tb_video2ram_window;

    localparam int AW = 14;
    localparam int LP = 20;
    localparam int BL = 4;
    localparam int TA = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  R = '0, G = '0, B = '0;
    logic [11:0] counterX = '0, counterY = '0;
    logic        line_doubler = 1'b0;

    logic [23:0]   wrdata, wrdata2;
    logic [AW-1:0] wraddr, wraddr2;
    logic          wren, wren2, wrclock, wrclock2;
    logic          starttrigger, starttrigger2, frame_active, frame_active2;
    logic [1:0]    line_slot, line_slot2;

    int total = 0;
    int bad = 0;

    int            wr_count[16];
    int            first_x[16];
    logic [AW-1:0] first_addr[16];
    int            trig_count, trig_x, trig_y, trig2_count, data_err;
    logic [AW-1:0] trig_addr;
    logic          fa_in, fa_out;
    logic [1:0]    slot_mid;

    always #5 clock = ~clock;

    video2ram_window #(
        .DATA_WIDTH(24), .ADDR_BITS(AW), .LINE_PIXELS(LP), .BUFFER_LINES(BL), .TRIGGER_ADDR(TA),
        .H_START_P(4), .V_END_P(10), .H_START_D(1), .V_END_D(14), .GAP_START_D(5), .GAP_END_D(7)
    ) dut (
        .clock(clock), .reset(reset), .R(R), .G(G), .B(B),
        .counterX(counterX), .counterY(counterY), .line_doubler(line_doubler),
        .wrdata(wrdata), .wraddr(wraddr), .wren(wren), .wrclock(wrclock),
        .starttrigger(starttrigger), .line_slot(line_slot), .frame_active(frame_active)
    );

    // trigger address equal to the ring size: must never fire
    video2ram_window #(
        .DATA_WIDTH(24), .ADDR_BITS(AW), .LINE_PIXELS(LP), .BUFFER_LINES(BL), .TRIGGER_ADDR(BL * LP),
        .H_START_P(4), .V_END_P(10), .H_START_D(1), .V_END_D(14), .GAP_START_D(5), .GAP_END_D(7)
    ) dut_nt (
        .clock(clock), .reset(reset), .R(R), .G(G), .B(B),
        .counterX(counterX), .counterY(counterY), .line_doubler(line_doubler),
        .wrdata(wrdata2), .wraddr(wraddr2), .wren(wren2), .wrclock(wrclock2),
        .starttrigger(starttrigger2), .line_slot(line_slot2), .frame_active(frame_active2)
    );

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) begin
            wr_count[i]   = 0;
            first_x[i]    = -1;
            first_addr[i] = '1;
        end
        trig_count  = 0;
        trig_x      = -1;
        trig_y      = -1;
        trig_addr   = '1;
        trig2_count = 0;
        data_err    = 0;
    endtask

    task automatic tick(input int x, input int y);
        counterX = 12'(x);
        counterY = 12'(y);
        R = 8'(y);
        G = 8'(x);
        B = 8'h5A;
        @(posedge clock);
        #1;
        if (wren) begin
            if (wr_count[y] == 0) begin
                first_x[y]    = x;
                first_addr[y] = wraddr;
            end
            wr_count[y]++;
            if (wrdata !== {8'(y), 8'(x), 8'h5A}) data_err++;
        end
        if (starttrigger) begin
            trig_count++;
            trig_x    = x;
            trig_y    = y;
            trig_addr = wraddr;
        end
        if (starttrigger2) trig2_count++;
        if (x == 10 && y == 3)  fa_in = frame_active;
        if (x == 10 && y == 12) fa_out = frame_active;
        if (x == 10 && y == 5)  slot_mid = line_slot;
    endtask

    task automatic run_frame(input logic mode_start, input int toggle_y, input logic mode_after);
        line_doubler = mode_start;
        for (int y = 0; y < 16; y++) begin
            if (y == toggle_y) line_doubler = mode_after;
            for (int x = 0; x < 32; x++) tick(x, y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(5, 5);
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%0d exp=0", wren); end
        total++; if (starttrigger !== 1'b0) begin bad++; $display("FAIL reset_trig got=%0d exp=0", starttrigger); end
        total++; if (wrdata !== 24'd0) begin bad++; $display("FAIL reset_wrdata got=%0h exp=0", wrdata); end
        total++; if (wraddr !== 14'd0) begin bad++; $display("FAIL reset_wraddr got=%0d exp=0", wraddr); end
        total++; if (line_slot !== 2'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", line_slot); end
        total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL reset_frame_active got=%0d exp=0", frame_active); end
        reset = 1'b0;
    endtask

    task automatic test_progressive();
        clear_stats();
        run_frame(1'b0, -1, 1'b0);
        for (int y = 0; y < 16; y++) begin
            total++;
            if (wr_count[y] !== ((y < 10) ? LP : 0)) begin
                bad++; $display("FAIL prog_count y=%0d got=%0d exp=%0d", y, wr_count[y], (y < 10) ? LP : 0);
            end
            if (y < 10) begin
                total++;
                if (first_x[y] !== 4) begin bad++; $display("FAIL prog_first_x y=%0d got=%0d exp=4", y, first_x[y]); end
                total++;
                if (first_addr[y] !== 14'((y % 4) * LP)) begin
                    bad++; $display("FAIL prog_first_addr y=%0d got=%0d exp=%0d", y, first_addr[y], (y % 4) * LP);
                end
            end
        end
        total++; if (data_err !== 0) begin bad++; $display("FAIL prog_wrdata errors got=%0d exp=0", data_err); end
        total++; if (fa_in !== 1'b1) begin bad++; $display("FAIL prog_frame_active_in got=%0d exp=1", fa_in); end
        total++; if (fa_out !== 1'b0) begin bad++; $display("FAIL prog_frame_active_out got=%0d exp=0", fa_out); end
        total++; if (slot_mid !== 2'd1) begin bad++; $display("FAIL prog_slot_line5 got=%0d exp=1", slot_mid); end
    endtask

    task automatic test_trigger();
        for (int f = 0; f < 2; f++) begin
            clear_stats();
            run_frame(1'b0, -1, 1'b0);
            total++; if (trig_count !== 1) begin bad++; $display("FAIL trig_count frame=%0d got=%0d exp=1", f, trig_count); end
            total++; if (trig_y !== 2) begin bad++; $display("FAIL trig_line frame=%0d got=%0d exp=2", f, trig_y); end
            total++; if (trig_x !== 4) begin bad++; $display("FAIL trig_x frame=%0d got=%0d exp=4", f, trig_x); end
            total++; if (trig_addr !== 14'(TA)) begin bad++; $display("FAIL trig_addr frame=%0d got=%0d exp=%0d", f, trig_addr, TA); end
            total++; if (trig2_count !== 0) begin bad++; $display("FAIL trig_unreachable frame=%0d got=%0d exp=0", f, trig2_count); end
        end
    endtask

    task automatic test_doubler();
        int k;
        bit written;
        clear_stats();
        run_frame(1'b1, -1, 1'b1);
        k = 0;
        for (int y = 0; y < 16; y++) begin
            written = (y < 5) || (y >= 8 && y < 14);
            total++;
            if (wr_count[y] !== (written ? LP : 0)) begin
                bad++; $display("FAIL dbl_count y=%0d got=%0d exp=%0d", y, wr_count[y], written ? LP : 0);
            end
            if (written) begin
                total++;
                if (first_x[y] !== 1) begin bad++; $display("FAIL dbl_first_x y=%0d got=%0d exp=1", y, first_x[y]); end
                total++;
                if (first_addr[y] !== 14'((k % 4) * LP)) begin
                    bad++; $display("FAIL dbl_first_addr y=%0d got=%0d exp=%0d", y, first_addr[y], (k % 4) * LP);
                end
                k++;
            end
        end
        total++; if (trig_count !== 1) begin bad++; $display("FAIL dbl_trig_count got=%0d exp=1", trig_count); end
        total++; if (data_err !== 0) begin bad++; $display("FAIL dbl_wrdata errors got=%0d exp=0", data_err); end
    endtask

    task automatic test_mode_latch();
        clear_stats();
        run_frame(1'b0, 3, 1'b1);
        total++; if (first_x[5] !== 4) begin bad++; $display("FAIL latch_first_x got=%0d exp=4", first_x[5]); end
        total++; if (wr_count[6] !== LP) begin bad++; $display("FAIL latch_no_gap got=%0d exp=%0d", wr_count[6], LP); end
        total++; if (wr_count[11] !== 0) begin bad++; $display("FAIL latch_v_end got=%0d exp=0", wr_count[11]); end
        clear_stats();
        run_frame(1'b1, -1, 1'b1);
        total++; if (first_x[0] !== 1) begin bad++; $display("FAIL latch_next_first_x got=%0d exp=1", first_x[0]); end
        total++; if (wr_count[6] !== 0) begin bad++; $display("FAIL latch_next_gap got=%0d exp=0", wr_count[6]); end
    endtask

    task automatic test_reset_mid();
        int sum;
        line_doubler = 1'b0;
        clear_stats();
        for (int y = 0; y < 2; y++) for (int x = 0; x < 32; x++) tick(x, y);
        for (int x = 0; x <= 16; x++) tick(x, 2);
        total++; if (wren !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_wren got=%0d exp=1", wren); end
        reset = 1'b1;
        tick(17, 2);
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL rst_mid_wren got=%0d exp=0", wren); end
        total++; if (starttrigger !== 1'b0) begin bad++; $display("FAIL rst_mid_trig got=%0d exp=0", starttrigger); end
        total++; if (line_slot !== 2'd0) begin bad++; $display("FAIL rst_mid_slot got=%0d exp=0", line_slot); end
        reset = 1'b0;
        clear_stats();
        for (int x = 18; x < 32; x++) tick(x, 2);
        for (int y = 3; y < 16; y++) for (int x = 0; x < 32; x++) tick(x, y);
        sum = 0;
        for (int y = 0; y < 16; y++) sum += wr_count[y];
        total++; if (sum !== 0) begin bad++; $display("FAIL rst_mid_quiet got=%0d exp=0", sum); end
        clear_stats();
        run_frame(1'b0, -1, 1'b0);
        total++; if (wr_count[0] !== LP) begin bad++; $display("FAIL rst_mid_restart_count got=%0d exp=%0d", wr_count[0], LP); end
        total++; if (first_addr[0] !== 14'd0) begin bad++; $display("FAIL rst_mid_restart_addr got=%0d exp=0", first_addr[0]); end
    endtask

    task automatic test_abort();
        line_doubler = 1'b0;
        clear_stats();
        for (int y = 0; y < 3; y++) for (int x = 0; x < 32; x++) tick(x, y);
        for (int x = 0; x <= 12; x++) tick(x, 3);
        total++; if (line_slot !== 2'd3) begin bad++; $display("FAIL abort_pre_slot got=%0d exp=3", line_slot); end
        tick(0, 0);
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL abort_wren got=%0d exp=0", wren); end
        total++; if (line_slot !== 2'd0) begin bad++; $display("FAIL abort_slot got=%0d exp=0", line_slot); end
        clear_stats();
        for (int x = 1; x < 32; x++) tick(x, 0);
        total++; if (wr_count[0] !== LP) begin bad++; $display("FAIL abort_count got=%0d exp=%0d", wr_count[0], LP); end
        total++; if (first_addr[0] !== 14'd0) begin bad++; $display("FAIL abort_addr got=%0d exp=0", first_addr[0]); end
        total++; if (first_x[0] !== 4) begin bad++; $display("FAIL abort_first_x got=%0d exp=4", first_x[0]); end
    endtask

    initial begin
        clear_stats();
        fa_in = 1'b0;
        fa_out = 1'b1;
        slot_mid = '0;
        test_reset();
        test_progressive();
        test_trigger();
        test_doubler();
        test_mode_latch();
        test_reset_mid();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
